// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared widths, constants and sizing helper for the instruction prefetch queue
package ifq_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Bits needed to hold a counter ranging over 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/ifq_sync_fifo.sv
// rtl/ifq_sync_fifo.sv - DEPTH x XLEN synchronous FIFO with clear, holding all prefetch storage
module ifq_sync_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_data_i,
    input  logic            pop_i,
    output logic [XLEN-1:0] head_o,
    output logic [CW-1:0]   count_o
);
    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - instruction prefetcher with redirect flush; IFQ_PERF_COUNTERS_EN adds perf counters
module ifetch_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
`ifdef IFQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]     perf_stall_cycles_o,
    output logic [31:0]     perf_flushed_o
`endif
);
    localparam int CW = cnt_width(DEPTH);
    localparam int OW = cnt_width(MAX_OUTSTANDING);

    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] fifo_head;
    logic            grant, push, pop, drop;
    int              live;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        // Live responses already own a FIFO slot, so requests stop before overfilling.
        live          = int'(fifo_count) + int'(outstanding_q) - int'(discard_q);
        imem_req_o    = !rst && !redirect_i && (int'(outstanding_q) < MAX_OUTSTANDING) && (live < DEPTH);
        imem_addr_o   = fetch_addr_q;
        grant         = imem_req_o && imem_gnt_i;
        instr_valid_o = (fifo_count != '0);
        drop          = imem_rvalid_i && (redirect_i || (discard_q != '0));
        push          = imem_rvalid_i && !drop;
        pop           = instr_valid_o && instr_ready_i && !redirect_i;

        outstanding_d = outstanding_q;
        if (grant && !imem_rvalid_i) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!grant && imem_rvalid_i) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        discard_d    = discard_q;
        fetch_addr_d = fetch_addr_q;
        head_pc_d    = head_pc_q;
        if (redirect_i) begin
            discard_d    = outstanding_d;
            fetch_addr_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            head_pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
        end else begin
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (grant) begin
                fetch_addr_d = fetch_addr_q + XLEN'(INSTR_BYTES);
            end
            if (pop) begin
                head_pc_d = head_pc_q + XLEN'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr_q  <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifq_sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (redirect_i),
        .push_i     (push),
        .push_data_i(imem_rdata_i),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    assign instr_o    = instr_valid_o ? fifo_head : NOP_INSTR;
    assign pc_o       = head_pc_q;
    assign pc_plus4_o = head_pc_q + XLEN'(INSTR_BYTES);

`ifdef IFQ_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flushed_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            flushed_cnt_q <= '0;
        end else begin
            if (instr_ready_i && !instr_valid_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (drop && (flushed_cnt_q != '1)) begin
                flushed_cnt_q <= flushed_cnt_q + 1'b1;
            end
        end
    end

    assign perf_stall_cycles_o = stall_cnt_q;
    assign perf_flushed_o      = flushed_cnt_q;
`endif
endmodule

// File: doc/ifetch_prefetch_queue.md
Name: ifetch_prefetch_queue

Overview:
- Instruction prefetch unit directly upstream of the fetch stage's IF/ID register.
- Decouples the pipeline from a variable-latency instruction memory bus using a request/grant/rvalid handshake.
- Streams sequential 32-bit instructions, with their PC and PC+4, into a small FIFO.
- On a taken branch or jump redirect from Execute, flushes the FIFO and discards stale in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered bus requests. Range 1..DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_i  in  1  taken branch/jump from Execute (PCSrcE).
- redirect_pc_i  in  32  redirect target (PCTargetE); low 2 bits ignored.
- imem_req_o  out  1  bus request.
- imem_addr_o  out  32  word-aligned request address.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; responses return in request order.
- imem_rdata_i  in  32  response instruction.
- instr_valid_o  out  1  FIFO head is valid.
- instr_ready_i  in  1  consumer accepts the head (driven as !StallF by the top level).
- instr_o  out  32  head instruction.
- pc_o  out  32  head PC.
- pc_plus4_o  out  32  pc_o + 4, modulo 2^32.

Behaviour:
- Reset, when rst=1 at the clock edge:
  - fetch_addr = head_pc = RESET_PC.
  - FIFO count, outstanding and discard_cnt all 0.
  - Outputs: imem_req_o=0, instr_valid_o=0, instr_o=32'h00000013 (NOP), pc_o=RESET_PC.
- Request:
  - imem_req_o = !redirect_i && outstanding < MAX_OUTSTANDING && (count + outstanding − discard_cnt) < DEPTH.
  - This reserves a FIFO slot for every live response.
  - imem_addr_o = fetch_addr.
  - Handshake completes when req && gnt; fetch_addr += 4 (wraps at 2^32) and outstanding increments.
  - While req=1 and gnt=0, imem_addr_o is held stable.
  - req is withdrawn only in a redirect cycle; the bus tolerates this withdrawal.
- Response:
  - On rvalid, outstanding decrements.
  - If discard_cnt>0: the data is dropped and discard_cnt decrements.
  - Otherwise: imem_rdata_i is pushed to the FIFO tail.
  - Grant and rvalid in the same cycle: outstanding is unchanged.
- Output:
  - instr_valid_o = (count != 0), combinational from registered FIFO state.
  - Pop when valid && ready: head advances and head_pc += 4.
  - Push and pop in the same cycle leaves count unchanged. This is legal at full because the slot is reserved.
  - When invalid, instr_o = NOP and pc_o = head_pc.
- Redirect (highest priority over push, pop and request):
  - FIFO is cleared.
  - fetch_addr = head_pc = {redirect_pc_i[31:2], 2'b00}.
  - discard_cnt = outstanding after this cycle's rvalid is accounted; any rvalid in this cycle is also dropped.
  - No grant is possible because req=0.
  - First instruction from the new target is valid no earlier than 1 cycle + bus latency after the redirect.
- Back-to-back redirects: each recomputes discard_cnt from the current outstanding count, so no stale data is ever pushed.
- Reset asserted mid-transfer clears all state; the instruction memory shares rst, so no responses arrive after reset.
- Invariant: count + outstanding − discard_cnt ≤ DEPTH. The bench asserts this every cycle.
- Logical state (derived from counters): RUN (discard_cnt=0), FLUSH (discard_cnt>0). New requests are still issued in FLUSH.

Optional Feature:
- Macro: IFQ_PERF_COUNTERS_EN.
- When defined:
  - Adds output perf_stall_cycles_o [31:0]: increments each cycle with instr_ready_i=1 && instr_valid_o=0.
  - Adds output perf_flushed_o [31:0]: increments once per discarded response.
  - Both counters saturate at all-ones and clear on rst.
- When undefined: neither port nor logic exists; the core is behaviourally identical.

Decomposition:
- Package ifq_pkg:
  - XLEN=32.
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h00000013.
  - Helper function clog2-based count width.
- Sub-module ifq_sync_fifo:
  - Parameterised DEPTH×32 storage with push/pop/clear, count output and synchronous rst.
  - Holds all storage; the top holds counters, PC tracking and the request logic.

Test Plan:
- Sequential stream with a zero-wait bus (gnt=1, rvalid one cycle later), ready=1 → pc_o sequence 0x0, 0x4, 0x8, one instruction per cycle after a 2-cycle fill; pc_plus4_o = pc_o+4.
- Consumer stall: ready=0 for 10 cycles → FIFO fills to 4; req drops once 4+outstanding would exceed DEPTH; no data lost; after release, 4 back-to-back valid pops.
- Redirect with 2 outstanding requests: redirect_i=1, target 0x100 → two responses dropped; next valid head has pc_o=0x100 with the instruction from addr 0x100.
- Redirect in the same cycle as rvalid and as a pop → FIFO empty next cycle; that response is dropped; discard_cnt=1 if one request remains outstanding.
- Grant withheld for 5 cycles → imem_addr_o stable; outstanding never exceeds MAX_OUTSTANDING=2; rst asserted mid-wait → outputs return to reset values the next cycle.
- With IFQ_PERF_COUNTERS_EN defined: empty FIFO with ready=1 for 3 cycles → perf_stall_cycles_o=3; redirect that discards 2 responses → perf_flushed_o=2.
